// File: rtl/adler32_sequencer.sv
// Adler-32 checksum sequencer: one shared mod-add unit time-shared between the A and B sums.
// Optional `ADLER_ABORT_EN adds an abort input that drops the current message.
module adler32_sequencer #(
  parameter int unsigned MOD    = 65521,
  parameter int unsigned INIT_A = 1
) (
  input  logic        clk,
  input  logic        rst,
`ifdef ADLER_ABORT_EN
  input  logic        abort,
`endif
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        busy,
  output logic        sum_valid,
  output logic [31:0] checksum
);

  localparam int unsigned SUM_W = 16;
  localparam logic [SUM_W:0] MOD_X = (SUM_W + 1)'(MOD);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_ADD_A = 3'd2;
  localparam logic [2:0] S_ADD_B = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state, state_next;
  logic [SUM_W-1:0] a, a_next, b, b_next;
  logic [7:0]       byte_q, byte_next;
  logic             last_q, last_next;
  logic [31:0]      checksum_next;

  logic [SUM_W-1:0] mod_s_c, mod_x_c, mod_r_c;
  logic [SUM_W:0]   mod_sum_c;

  // Shared modular adder; operand mux selects the A or B update
  always_comb begin
    if (state == S_ADD_A) begin
      mod_s_c = a;
      mod_x_c = {8'd0, byte_q};
    end else begin
      mod_s_c = b;
      mod_x_c = a;
    end
    mod_sum_c = {1'b0, mod_s_c} + {1'b0, mod_x_c};
    mod_r_c   = SUM_W'((mod_sum_c >= MOD_X) ? (mod_sum_c - MOD_X) : mod_sum_c);
  end

  // Next-state and datapath control
  always_comb begin
    state_next    = state;
    a_next        = a;
    b_next        = b;
    byte_next     = byte_q;
    last_next     = last_q;
    checksum_next = checksum;
    case (state)
      S_IDLE: begin
        if (start) begin
          a_next        = SUM_W'(INIT_A);
          b_next        = '0;
          checksum_next = '0;
          state_next    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (in_valid && in_ready) begin
          byte_next  = in_data;
          last_next  = in_last;
          state_next = S_ADD_A;
        end
      end
      S_ADD_A: begin
        a_next     = mod_r_c;
        state_next = S_ADD_B;
      end
      S_ADD_B: begin
        b_next = mod_r_c;
        if (last_q) begin
          checksum_next = {mod_r_c, a};
          state_next    = S_DONE;
        end else begin
          state_next = S_WAIT;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
`ifdef ADLER_ABORT_EN
    if (abort && (state != S_IDLE)) begin
      state_next    = S_IDLE;
      checksum_next = checksum;
    end
`endif
  end

  // State, sums and registered output decodes
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      a         <= SUM_W'(INIT_A);
      b         <= '0;
      byte_q    <= '0;
      last_q    <= 1'b0;
      checksum  <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      sum_valid <= 1'b0;
    end else begin
      state     <= state_next;
      a         <= a_next;
      b         <= b_next;
      byte_q    <= byte_next;
      last_q    <= last_next;
      checksum  <= checksum_next;
      in_ready  <= (state_next == S_WAIT);
      busy      <= (state_next != S_IDLE);
      sum_valid <= (state_next == S_DONE);
    end
  end

endmodule

// File: tb/tb_adler32_sequencer.sv
// Directed self-checking bench for adler32_sequencer; honours `ADLER_ABORT_EN when defined.
module tb_adler32_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        busy;
  logic        sum_valid;
  logic [31:0] checksum;
`ifdef ADLER_ABORT_EN
  logic        abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int accepted = 0;

  adler32_sequencer dut (
    .clk       (clk),
    .rst       (rst),
`ifdef ADLER_ABORT_EN
    .abort     (abort),
`endif
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .busy      (busy),
    .sum_valid (sum_valid),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sum_valid) pulses <= pulses + 1;
    if (in_valid && in_ready) accepted <= accepted + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while IDLE; returns at the negedge of the first WAIT cycle
  task automatic start_msg(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_cks_clr"}, checksum, 32'd0);
  endtask

  // Presents one byte; returns at the negedge right after the accepting edge
  task automatic send_byte(input logic [7:0] d, input logic l, input bit hold, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!ok && waits < 40) begin
      if (in_ready) ok = 1'b1;
      else waits++;
      @(negedge clk);
    end
    if (!hold) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    check("accept", 32'(ok), 32'd1);
  endtask

  // Entered at the negedge of cycle n+1 after the last byte was accepted in cycle n
  task automatic wait_sum(input string tag, input logic [31:0] exp);
    check({tag, "_sv_n1"}, 32'(sum_valid), 32'd0);
    check({tag, "_busy_n1"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, "_sv_n2"}, 32'(sum_valid), 32'd0);
    @(negedge clk);
    check({tag, "_sv_n3"}, 32'(sum_valid), 32'd1);
    check({tag, "_cks"}, checksum, exp);
    @(negedge clk);
    check({tag, "_sv_n4"}, 32'(sum_valid), 32'd0);
    check({tag, "_busy_n4"}, 32'(busy), 32'd0);
    check({tag, "_cks_hold"}, checksum, exp);
  endtask

  initial begin
    int w;
    int p0;
    int acc0;
    logic [7:0] wiki [9];
    wiki = '{8'h57, 8'h69, 8'h6B, 8'h69, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sv", 32'(sum_valid), 32'd0);
    check("rst_cks", checksum, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(in_ready), 32'd0);

    // Single byte "a"
    start_msg("a");
    send_byte(8'h61, 1'b1, 1'b0, w);
    wait_sum("a", 32'h0062_0062);

    // "abc" with valid held high: ready once per three cycles
    start_msg("abc");
    send_byte(8'h61, 1'b0, 1'b1, w);
    check("abc_wait0", 32'(w), 32'd0);
    check("abc_gap_ready", 32'(in_ready), 32'd0);
    send_byte(8'h62, 1'b0, 1'b1, w);
    check("abc_wait1", 32'(w), 32'd2);
    send_byte(8'h63, 1'b1, 1'b0, w);
    check("abc_wait2", 32'(w), 32'd2);
    wait_sum("abc", 32'h024D_0127);

    // "Wikipedia" with random idle gaps
    acc0 = accepted;
    start_msg("wiki");
    for (int i = 0; i < 9; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(wiki[i], (i == 8) ? 1'b1 : 1'b0, 1'b0, w);
    end
    wait_sum("wiki", 32'h11E6_0398);
    check("wiki_count", 32'(accepted - acc0), 32'd9);

    // 300 x 0xFF: both sums wrap
    start_msg("ff");
    for (int i = 0; i < 300; i++)
      send_byte(8'hFF, (i == 299) ? 1'b1 : 1'b0, (i == 299) ? 1'b0 : 1'b1, w);
    wait_sum("ff", 32'hB90F_2AE4);

    // Reset after two bytes discards the message
    start_msg("rmid");
    send_byte(8'h61, 1'b0, 1'b0, w);
    send_byte(8'h62, 1'b0, 1'b0, w);
    p0 = pulses;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_ready", 32'(in_ready), 32'd0);
    check("rmid_cks", checksum, 32'd0);
    repeat (4) @(negedge clk);
    check("rmid_nopulse", 32'(pulses - p0), 32'd0);
    start_msg("rmid_a");
    send_byte(8'h61, 1'b1, 1'b0, w);
    wait_sum("rmid_a", 32'h0062_0062);

`ifdef ADLER_ABORT_EN
    // Abort after two bytes behaves like reset for the message
    start_msg("abrt");
    send_byte(8'h61, 1'b0, 1'b0, w);
    send_byte(8'h62, 1'b0, 1'b0, w);
    p0 = pulses;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abrt_busy", 32'(busy), 32'd0);
    check("abrt_cks", checksum, 32'd0);
    repeat (4) @(negedge clk);
    check("abrt_nopulse", 32'(pulses - p0), 32'd0);
    start_msg("abrt_a");
    send_byte(8'h61, 1'b1, 1'b0, w);
    wait_sum("abrt_a", 32'h0062_0062);
`endif

    // Start pulses mid-message are ignored
    start_msg("sig");
    send_byte(8'h61, 1'b0, 1'b0, w);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h62, 1'b0, 1'b0, w);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("sig_ready", 32'(in_ready), 32'd1);
    send_byte(8'h63, 1'b1, 1'b0, w);
    wait_sum("sig", 32'h024D_0127);

    // Start in the cycle right after DONE
    start_msg("b2b");
    send_byte(8'h61, 1'b1, 1'b0, w);
    wait_sum("b2b", 32'h0062_0062);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adler32_sequencer.md
# adler32_sequencer

Controller that sequences the Adler-32 checksum datapath over a byte stream. Accepts bytes on a valid/ready handshake, time-shares one add-and-conditional-subtract modulus unit between the A and B running sums, and frames each message between a `start` pulse and an `in_last`-tagged byte. Sits between the byte source and any consumer of the 32-bit checksum. Posts the result with a one-cycle `sum_valid` strobe.

## Interface
Parameters:
- `MOD`, 65521: Adler modulus; both sums are always held in [0, MOD-1].
- `INIT_A`, 1: value loaded into A on `start`. B always loads 0.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: begin a new message; honoured only in IDLE.
- `in_valid`, in, 1: byte present on `in_data`.
- `in_data`, in, 8: message byte.
- `in_last`, in, 1: qualifies `in_data` as the final byte of the message.
- `in_ready`, out, 1: controller accepts a byte this cycle.
- `busy`, out, 1: high in every state except IDLE.
- `sum_valid`, out, 1: one-cycle strobe; `checksum` is final.
- `checksum`, out, 32: `{B[15:0], A[15:0]}`; holds its value until the next `start`.
- `abort`, in, 1: present only with `ADLER_ABORT_EN`.

## Operation
- Shared unit: `r = s + x` computed 17 bits wide; if `r >= MOD` then `r - MOD`, else `r`. Inputs s < MOD and x < MOD, so one subtraction suffices. A single instance is used; its operand mux is driven by the FSM.
- **IDLE**
  - `in_ready`=0.
  - On `start`: A←INIT_A, B←0, `checksum`←0, go to WAIT.
- **WAIT**
  - `in_ready`=1.
  - On `in_valid`: latch the byte and `in_last`, go to ADD_A.
- **ADD_A**
  - A←mod(A + byte). Go to ADD_B.
- **ADD_B**
  - B←mod(B + A), using the A value updated in ADD_A.
  - If the latched last flag is set, go to DONE; otherwise go to WAIT.
- **DONE**
  - `checksum`←{B,A}, `sum_valid`=1, go to IDLE.
- Boundary rules:
  - `start` outside IDLE is ignored.
  - A message is at least one byte; `in_last` on the first byte is legal.
  - Bytes presented while `in_ready`=0 are not consumed; the source must hold them.
  - The FSM decodes its state fully; any unreachable encoding returns to IDLE.

## Timing
- Reset values: state IDLE, A=1, B=0, `checksum`=0, `in_ready`=0, `busy`=0, `sum_valid`=0.
- `rst` mid-message: everything returns to reset values on the next edge; the partial message is discarded and no `sum_valid` is issued.
- A transfer occurs on a `clk` edge with `in_valid && in_ready`.
- `in_ready` is a registered state decode; it never depends combinationally on `in_valid`.
- Throughput: 3 cycles per byte (WAIT, ADD_A, ADD_B), assuming `in_valid` is held high.
- Latency:
  - `start` in cycle 0 gives `in_ready`=1 from cycle 1.
  - The last byte accepted in cycle n gives `sum_valid` in cycle n+3.
  - `busy` falls in cycle n+4.
- `sum_valid` and the updated `checksum` first appear in the same cycle.
- A `start` in the cycle immediately after DONE is honoured.

## Configuration
- `ADLER_ABORT_EN` defined:
  - Adds the `abort` input.
  - `abort`=1 in any non-IDLE state returns the FSM to IDLE on the next edge.
  - No `sum_valid` is issued and `checksum` is left at 0.
  - If `abort` and `rst` are both high, `rst` takes precedence.
- `ADLER_ABORT_EN` undefined:
  - No `abort` port.
  - A message can be terminated only by `in_last` or `rst`.

## Test plan
- `start`, then byte 0x61 with `in_last` → `sum_valid` 3 cycles after acceptance, `checksum`=0x00620062.
- `start`, then "abc" (0x61, 0x62, 0x63), last on 0x63, `in_valid` held high → `in_ready` high once per 3 cycles, `checksum`=0x024D0127.
- `start`, then "Wikipedia" (9 bytes) with random `in_valid` gaps → `checksum`=0x11E60398, and no byte is dropped or duplicated.
- `start`, then 300 bytes of 0xFF → both sums wrap (modulo path exercised), `checksum`=0xB90F2AE4.
- `rst` pulsed after 2 bytes of "abc", then a new `start` and "a" → no `sum_valid` for the aborted message, then `checksum`=0x00620062. Repeat with `abort` when `ADLER_ABORT_EN` is defined; the result must be identical.
- `start` pulsed again during a message → ignored, and the result is unchanged.
